// File: rtl/monitor_stimulus_player.sv
// monitor_stimulus_player
// Replays timed events {delta, mask, data, last} queued by a host into a
// generated monitor. Each event fires at its scheduled tick as a one-cycle
// strobe on new_input together with the lane values on input_data.
// Build option: define STIM_HOLD_DATA_EN to let input_data keep the last fired
// value per lane on non-fire cycles and on unmasked lanes. Without it,
// input_data is zero whenever a lane is not being fired.
module monitor_stimulus_player #(
    parameter int NUM_CH  = 2,
    parameter int DATA_W  = 64,
    parameter int DELTA_W = 32,
    parameter int DEPTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     start,
    input  logic                     ev_valid,
    output logic                     ev_ready,
    input  logic [DELTA_W-1:0]       ev_delta,
    input  logic [NUM_CH-1:0]        ev_mask,
    input  logic [NUM_CH*DATA_W-1:0] ev_data,
    input  logic                     ev_last,
    output logic [NUM_CH-1:0]        new_input,
    output logic [NUM_CH*DATA_W-1:0] input_data,
    output logic                     busy,
    output logic                     done,
    output logic                     underrun,
    output logic [31:0]              fired_count
);

    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW        = AW + 1;
    localparam int DW_ALL    = NUM_CH * DATA_W;
    localparam int DATA_LSB  = 1;
    localparam int MASK_LSB  = DATA_LSB + DW_ALL;
    localparam int DELTA_LSB = MASK_LSB + NUM_CH;
    localparam int EW        = DELTA_LSB + DELTA_W;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Event FIFO: entry layout is {delta, mask, data, last} with last at bit 0.
    logic [EW-1:0]      mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [CW-1:0]      count_q;
    logic [CW-1:0]      count_d;
    logic               full_s;
    logic               empty_s;
    logic               push_s;
    logic               pop_s;

    logic [EW-1:0]      head_s;
    logic [DELTA_W-1:0] head_delta_s;
    logic [NUM_CH-1:0]  head_mask_s;
    logic [DW_ALL-1:0]  head_data_s;
    logic               head_last_s;

    // Replay control and registered outputs.
    state_t             state_q;
    state_t             state_d;
    logic [DELTA_W-1:0] elapsed_q;
    logic [DELTA_W-1:0] elapsed_d;
    logic [DELTA_W-1:0] eff_delta_s;
    logic               due_s;
    logic [NUM_CH-1:0]  new_input_q;
    logic [NUM_CH-1:0]  new_input_d;
    logic [DW_ALL-1:0]  input_data_q;
    logic [DW_ALL-1:0]  input_data_d;
    logic               underrun_q;
    logic               underrun_d;
    logic [31:0]        fired_q;
    logic [31:0]        fired_d;
    logic               busy_q;
    logic               done_q;
    logic               ev_ready_q;

    assign full_s  = (count_q == DEPTH_C);
    assign empty_s = (count_q == '0);
    assign push_s  = ev_valid && !full_s;
    assign pop_s   = due_s;

    assign head_s       = mem_q[rd_ptr_q];
    assign head_delta_s = head_s[DELTA_LSB +: DELTA_W];
    assign head_mask_s  = head_s[MASK_LSB +: NUM_CH];
    assign head_data_s  = head_s[DATA_LSB +: DW_ALL];
    assign head_last_s  = head_s[0];

    // A zero delta is treated as one so that events never merge into a single cycle.
    assign eff_delta_s = (head_delta_s == '0) ? DELTA_W'(1) : head_delta_s;
    assign due_s       = (state_q == ST_RUN) && en && !empty_s && (elapsed_q >= eff_delta_s);

    // FIFO occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage write; contents need no reset because pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {ev_delta, ev_mask, ev_data, ev_last};
        end
    end

    // FIFO pointers and count; reset flushes every queued event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    // Next-state logic: replay state, elapsed tick counter, fire outputs, status.
    always_comb begin
        state_d     = state_q;
        elapsed_d   = elapsed_q;
        underrun_d  = underrun_q;
        fired_d     = fired_q;
        new_input_d = '0;
`ifdef STIM_HOLD_DATA_EN
        input_data_d = input_data_q;
`else
        input_data_d = '0;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    elapsed_d  = '0;
                    underrun_d = 1'b0;
                    fired_d    = 32'd0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (due_s) begin
                    new_input_d = head_mask_s;
                    for (int ch = 0; ch < NUM_CH; ch++) begin
                        if (head_mask_s[ch]) begin
                            input_data_d[ch*DATA_W +: DATA_W] = head_data_s[ch*DATA_W +: DATA_W];
                        end else begin
                            input_data_d[ch*DATA_W +: DATA_W] = input_data_d[ch*DATA_W +: DATA_W];
                        end
                    end
                    fired_d   = fired_q + 32'd1;
                    // The fire cycle itself is the first tick toward the next event.
                    elapsed_d = DELTA_W'(1);
                    if (elapsed_q > eff_delta_s) begin
                        underrun_d = 1'b1;
                    end else begin
                        underrun_d = underrun_q;
                    end
                    if (head_last_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (en) begin
                    if (&elapsed_q) begin
                        elapsed_d = elapsed_q;
                    end else begin
                        elapsed_d = elapsed_q + DELTA_W'(1);
                    end
                end else begin
                    elapsed_d = elapsed_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Replay FSM and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            elapsed_q    <= '0;
            underrun_q   <= 1'b0;
            fired_q      <= 32'd0;
            new_input_q  <= '0;
            input_data_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ev_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            elapsed_q    <= elapsed_d;
            underrun_q   <= underrun_d;
            fired_q      <= fired_d;
            new_input_q  <= new_input_d;
            input_data_q <= input_data_d;
            busy_q       <= (state_d == ST_RUN);
            done_q       <= (state_d == ST_DONE);
            ev_ready_q   <= (count_d != DEPTH_C);
        end
    end

    assign ev_ready    = ev_ready_q;
    assign new_input   = new_input_q;
    assign input_data  = input_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign underrun    = underrun_q;
    assign fired_count = fired_q;

endmodule

// File: tb/tb_monitor_stimulus_player.sv
// Directed bench for monitor_stimulus_player (default parameters).
// Fire times are counted in clock edges after the edge that samples start:
// the first event fires max(delta,1)+1 edges after start, later events
// max(delta,1) edges after the previous fire.
module tb_monitor_stimulus_player;

    localparam int NUM_CH  = 2;
    localparam int DATA_W  = 64;
    localparam int DELTA_W = 32;
    localparam int DEPTH   = 16;
`ifdef STIM_HOLD_DATA_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     en = 1'b1;
    logic                     start = 1'b0;
    logic                     ev_valid = 1'b0;
    logic                     ev_ready;
    logic [DELTA_W-1:0]       ev_delta = '0;
    logic [NUM_CH-1:0]        ev_mask = '0;
    logic [NUM_CH*DATA_W-1:0] ev_data = '0;
    logic                     ev_last = 1'b0;
    logic [NUM_CH-1:0]        new_input;
    logic [NUM_CH*DATA_W-1:0] input_data;
    logic                     busy;
    logic                     done;
    logic                     underrun;
    logic [31:0]              fired_count;

    monitor_stimulus_player #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DELTA_W(DELTA_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .start(start),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_delta(ev_delta),
        .ev_mask(ev_mask), .ev_data(ev_data), .ev_last(ev_last),
        .new_input(new_input), .input_data(input_data), .busy(busy),
        .done(done), .underrun(underrun), .fired_count(fired_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    // Edge counter; read only on negedges.
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] delta;
        logic [1:0]  mask;
        logic [63:0] d0;
        logic [63:0] d1;
        logic        last;
        int          exp_off;
        logic [1:0]  exp_ni;
        logic [63:0] exp_d0;
        logic [63:0] exp_d1;
    } vec_t;

    vec_t t1 [3];
    vec_t t2 [DEPTH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input logic [31:0] d, input logic [1:0] m,
                           input logic [63:0] a, input logic [63:0] b, input logic l);
        @(negedge clk);
        ev_valid = 1'b1; ev_delta = d; ev_mask = m; ev_data = {b, a}; ev_last = l;
        @(negedge clk);
        ev_valid = 1'b0;
    endtask

    task automatic do_start(output int s);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s = cyc;
    endtask

    task automatic wait_strobe(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (new_input !== '0) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic count_strobes(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (new_input !== '0) cnt++;
        end
    endtask

    initial begin
        int s;
        int at;
        int cnt;
        logic [63:0] h0;
        logic [63:0] h1;

        // Test vectors, expected values hand-derived.
        t1[0] = '{32'd500, 2'b11, 64'd1, 64'd1,     1'b0, 501, 2'b11, 64'd1, 64'd1};
        t1[1] = '{32'd3,   2'b11, 64'd2, 64'd2,     1'b0, 504, 2'b11, 64'd2, 64'd2};
        t1[2] = '{32'd1,   2'b01, 64'd3, 64'hDEAD,  1'b1, 505, 2'b01, 64'd3,
                  (HOLD ? 64'd2 : 64'd0)};
        h0 = 64'd3;
        h1 = 64'd2;
        for (int i = 0; i < DEPTH; i++) begin
            t2[i].delta   = (i == 4) ? 32'd0 : 32'd1;
            t2[i].mask    = (i == 6) ? 2'b00 : 2'((i % 3) + 1);
            t2[i].d0      = 64'd0 - 64'(i + 1);
            t2[i].d1      = 64'hA000 + 64'(i);
            t2[i].last    = (i == DEPTH - 1);
            t2[i].exp_off = i + 2;
            t2[i].exp_ni  = t2[i].mask;
            t2[i].exp_d0  = t2[i].mask[0] ? t2[i].d0 : (HOLD ? h0 : 64'd0);
            t2[i].exp_d1  = t2[i].mask[1] ? t2[i].d1 : (HOLD ? h1 : 64'd0);
            if (t2[i].mask[0]) h0 = t2[i].d0;
            if (t2[i].mask[1]) h1 = t2[i].d1;
        end

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(ev_ready), 64'd1);
        chk("rst_new_input", 64'(new_input), 64'd0);
        chk("rst_data", input_data[63:0] | input_data[127:64], 64'd0);
        chk("rst_busy_done_ur", {61'd0, busy, done, underrun}, 64'd0);
        chk("rst_fired", 64'(fired_count), 64'd0);
        rst = 1'b0;

        // T1: three-event trace with a long first delay.
        for (int i = 0; i < 3; i++) push_ev(t1[i].delta, t1[i].mask, t1[i].d0, t1[i].d1, t1[i].last);
        do_start(s);
        chk("t1_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 3; i++) begin
            wait_strobe(600, at);
            chk("t1_offset", 64'(at - s), 64'(t1[i].exp_off));
            chk("t1_new_input", 64'(new_input), 64'(t1[i].exp_ni));
            chk("t1_lane0", input_data[63:0], t1[i].exp_d0);
            chk("t1_lane1", input_data[127:64], t1[i].exp_d1);
        end
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_fired", 64'(fired_count), 64'd3);
        chk("t1_underrun", 64'(underrun), 64'd0);
        @(negedge clk);
        chk("t1_strobe_off", 64'(new_input), 64'd0);
        chk("t1_lane0_after", input_data[63:0], HOLD ? 64'd3 : 64'd0);
        chk("t1_lane1_after", input_data[127:64], HOLD ? 64'd2 : 64'd0);

        // T2: fill the FIFO without start, reject an extra push, then drain.
        for (int i = 0; i < DEPTH; i++) begin
            chk("t2_ready_before_push", 64'(ev_ready), 64'd1);
            push_ev(t2[i].delta, t2[i].mask, t2[i].d0, t2[i].d1, t2[i].last);
        end
        chk("t2_full_ready", 64'(ev_ready), 64'd0);
        @(negedge clk);
        ev_valid = 1'b1; ev_delta = 32'd1; ev_mask = 2'b11; ev_data = {64'hBAD, 64'hBAD}; ev_last = 1'b1;
        repeat (2) @(negedge clk);
        ev_valid = 1'b0;
        chk("t2_still_full", 64'(ev_ready), 64'd0);
        do_start(s);
        for (int i = 0; i < DEPTH; i++) begin
            if (t2[i].mask != 2'b00) begin
                wait_strobe(20, at);
                chk("t2_offset", 64'(at - s), 64'(t2[i].exp_off));
                chk("t2_new_input", 64'(new_input), 64'(t2[i].exp_ni));
                chk("t2_lane0", input_data[63:0], t2[i].exp_d0);
                chk("t2_lane1", input_data[127:64], t2[i].exp_d1);
                if (i == 0) chk("t2_ready_after_pop", 64'(ev_ready), 64'd1);
            end
        end
        chk("t2_done", 64'(done), 64'd1);
        chk("t2_fired", 64'(fired_count), 64'd16);

        // T3: en low for ten edges during a delta=20 wait.
        push_ev(32'd20, 2'b11, 64'h33, 64'h34, 1'b1);
        do_start(s);
        repeat (5) @(negedge clk);
        en = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (new_input !== '0) cnt++;
        end
        en = 1'b1;
        chk("t3_no_strobe_en_low", 64'(cnt), 64'd0);
        chk("t3_busy_en_low", 64'(busy), 64'd1);
        wait_strobe(40, at);
        chk("t3_offset", 64'(at - s), 64'd31);
        chk("t3_lane0", input_data[63:0], 64'h33);
        chk("t3_lane1", input_data[127:64], 64'h34);
        chk("t3_underrun", 64'(underrun), 64'd0);
        chk("t3_fired", 64'(fired_count), 64'd1);

        // T4: late event after a long empty wait raises underrun.
        do_start(s);
        count_strobes(100, cnt);
        chk("t4_idle_strobes", 64'(cnt), 64'd0);
        push_ev(32'd40, 2'b10, 64'h41, 64'h44, 1'b1);
        chk("t4_not_yet", 64'(new_input), 64'd0);
        @(negedge clk);
        chk("t4_new_input", 64'(new_input), 64'd2);
        chk("t4_lane0", input_data[63:0], HOLD ? 64'h33 : 64'd0);
        chk("t4_lane1", input_data[127:64], 64'h44);
        chk("t4_underrun", 64'(underrun), 64'd1);
        chk("t4_done", 64'(done), 64'd1);
        do_start(s);
        chk("t4_underrun_cleared", 64'(underrun), 64'd0);
        chk("t4_fired_cleared", 64'(fired_count), 64'd0);

        // T5: asynchronous reset during a run with events queued.
        push_ev(32'd15, 2'b11, 64'h51, 64'h52, 1'b0);
        for (int i = 0; i < 4; i++) push_ev(32'd60, 2'b11, 64'h60 + 64'(i), 64'h70, (i == 3));
        wait_strobe(40, at);
        chk("t5_fired_before", 64'(fired_count), 64'd1);
        chk("t5_busy_before", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_new_input", 64'(new_input), 64'd0);
        chk("t5_rst_data", input_data[63:0] | input_data[127:64], 64'd0);
        chk("t5_rst_status", {61'd0, busy, done, underrun}, 64'd0);
        chk("t5_rst_fired", 64'(fired_count), 64'd0);
        chk("t5_rst_ready", 64'(ev_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        do_start(s);
        count_strobes(100, cnt);
        chk("t5_fifo_flushed", 64'(cnt), 64'd0);
        chk("t5_busy_after", 64'(busy), 64'd1);
        chk("t5_fired_after", 64'(fired_count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
